// File: rtl/or1200_evcnt_pkg.sv
// Shared encodings for the event counter bank.
// Register selects and CTRL/STATUS bit positions.
package or1200_evcnt_pkg;

  localparam logic [1:0] SEL_COUNT  = 2'd0;
  localparam logic [1:0] SEL_THRESH = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_OVF = 0;
  localparam int ST_HIT = 1;

endpackage

// File: rtl/or1200_evcnt_chan.sv
// One event counter channel: COUNT, THRESH, CTRL, STATUS.
// In: clk, rst (async low), ev, per-register write strobes, wdata. Out: register state.
module or1200_evcnt_chan
  import or1200_evcnt_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev,
  input  logic             wr_count,
  input  logic             wr_thresh,
  input  logic             wr_ctrl,
  input  logic             wr_status,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] thresh,
  output logic [1:0]       ctrl,
  output logic [1:0]       status
);

  logic             inc;
  logic             at_max;
  logic             hold;
  logic [CNT_W-1:0] nxt;
  logic             ovf_set;
  logic             hit_set;
  logic [1:0]       set_v;
  logic [1:0]       clr_v;

  // A COUNT write in the same cycle drops the event entirely.
  assign inc     = ev & ctrl[CTRL_EN] & ~wr_count;
  assign at_max  = &count;
  assign hold    = (SATURATE != 0) && at_max;
  assign nxt     = hold ? count : count + 1'b1;
  assign ovf_set = inc & at_max;
  assign hit_set = inc & ~hold & (nxt == thresh);

  always_comb begin
    set_v         = '0;
    set_v[ST_OVF] = ovf_set;
    set_v[ST_HIT] = hit_set;
  end

  assign clr_v = wr_status ? wdata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      thresh <= '1;
      ctrl   <= '0;
      status <= '0;
    end else begin
      if (wr_count)
        count <= wdata;
      else if (inc)
        count <= nxt;
      if (wr_thresh)
        thresh <= wdata;
      if (wr_ctrl)
        ctrl <= wdata[1:0];
      // Set beats a concurrent write-1-to-clear.
      status <= set_v | (status & ~clr_v);
    end
  end

endmodule

// File: rtl/or1200_evcnt_bank.sv
// Bank of NUM_CH event counters with SPR-style register port.
// In: clk, rst, ev_i, we_i, re_i, addr_i, wdata_i. Out: rdata_o, rvalid_o, ovf_o, irq_o.
module or1200_evcnt_bank
  import or1200_evcnt_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int NUM_CH   = 4,
  parameter int SATURATE = 0,
  localparam int AW      = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ev_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [CNT_W-1:0]  wdata_i,
  output logic [CNT_W-1:0]  rdata_o,
  output logic              rvalid_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic              irq_o
);

  logic [31:0]      ch_idx;
  logic [1:0]       sel;
  logic [CNT_W-1:0] count_a  [NUM_CH];
  logic [CNT_W-1:0] thresh_a [NUM_CH];
  logic [1:0]       ctrl_a   [NUM_CH];
  logic [1:0]       status_a [NUM_CH];
  logic [NUM_CH-1:0] irq_v;
  logic [CNT_W-1:0] rmux;

  // Channel index widened so out-of-range channels simply match nothing.
  assign ch_idx = 32'(addr_i >> 2);
  assign sel    = addr_i[1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = we_i && (ch_idx == 32'(c));

    or1200_evcnt_chan #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ev        (ev_i[c]),
      .wr_count  (hit && sel == SEL_COUNT),
      .wr_thresh (hit && sel == SEL_THRESH),
      .wr_ctrl   (hit && sel == SEL_CTRL),
      .wr_status (hit && sel == SEL_STATUS),
      .wdata     (wdata_i),
      .count     (count_a[c]),
      .thresh    (thresh_a[c]),
      .ctrl      (ctrl_a[c]),
      .status    (status_a[c])
    );

    assign ovf_o[c] = status_a[c][ST_OVF];
    assign irq_v[c] = status_a[c][ST_HIT]
                    & ctrl_a[c][CTRL_IRQ_EN];
  end

  assign irq_o = |irq_v;

  always_comb begin
    rmux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == 32'(c)) begin
        unique case (sel)
          SEL_COUNT:  rmux = count_a[c];
          SEL_THRESH: rmux = thresh_a[c];
          SEL_CTRL:   rmux = CNT_W'(ctrl_a[c]);
          SEL_STATUS: rmux = CNT_W'(status_a[c]);
        endcase
      end
    end
  end

  // Read samples pre-write state, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= re_i;
      if (re_i)
        rdata_o <= rmux;
    end
  end

endmodule

// File: tb/tb_or1200_evcnt_bank.sv
// Directed bench for or1200_evcnt_bank.
// Wrap instance u_dut and saturate instance u_sat share all inputs.
module tb_or1200_evcnt_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  ev_i;
  logic        we_i;
  logic        re_i;
  logic [3:0]  addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_o;
  logic        rvalid_o;
  logic [3:0]  ovf_o;
  logic        irq_o;
  logic [15:0] rdata_s;
  logic        rvalid_s;
  logic [3:0]  ovf_s;
  logic        irq_s;

  int checks = 0;
  int errors = 0;

  or1200_evcnt_bank #(
    .CNT_W(16), .NUM_CH(4), .SATURATE(0)
  ) u_dut (
    .clk(clk), .rst(rst), .ev_i(ev_i), .we_i(we_i),
    .re_i(re_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .ovf_o(ovf_o), .irq_o(irq_o)
  );

  or1200_evcnt_bank #(
    .CNT_W(16), .NUM_CH(4), .SATURATE(1)
  ) u_sat (
    .clk(clk), .rst(rst), .ev_i(ev_i), .we_i(we_i),
    .re_i(re_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_s), .rvalid_o(rvalid_s),
    .ovf_o(ovf_s), .irq_o(irq_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input int ch, input int sel,
                    input logic [15:0] d);
    @(negedge clk);
    we_i    = 1'b1;
    addr_i  = 4'(ch * 4 + sel);
    wdata_i = d;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic rd(input int ch, input int sel,
                    output logic [15:0] d,
                    output logic [15:0] ds,
                    output logic v);
    @(negedge clk);
    re_i   = 1'b1;
    addr_i = 4'(ch * 4 + sel);
    @(negedge clk);
    re_i = 1'b0;
    d    = rdata_o;
    ds   = rdata_s;
    v    = rvalid_o & rvalid_s;
  endtask

  task automatic pulse(input logic [3:0] m, input int n);
    @(negedge clk);
    ev_i = m;
    repeat (n) @(negedge clk);
    ev_i = 4'b0;
  endtask

  task automatic test_reset;
    logic [15:0] d, ds, exp;
    logic v;
    rst = 1'b0; ev_i = '0; we_i = 0; re_i = 0;
    addr_i = '0; wdata_i = '0;
    #12;
    checks++;
    if (rdata_o !== 16'h0 || rvalid_o !== 1'b0 ||
        ovf_o !== 4'h0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out rdata=%h rvalid=%b ovf=%b irq=%b exp 0",
               rdata_o, rvalid_o, ovf_o, irq_o);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      for (int s = 0; s < 4; s++) begin
        rd(ch, s, d, ds, v);
        exp = (s == 1) ? 16'hFFFF : 16'h0;
        checks++;
        if (d !== exp || ds !== exp || v !== 1'b1) begin
          errors++;
          $display("FAIL reset_reg ch%0d sel%0d got %h/%h v=%b exp %h",
                   ch, s, d, ds, v, exp);
        end
      end
    end
  endtask

  task automatic test_count;
    logic [15:0] d, ds;
    logic v;
    wr(0, 2, 16'h0001);
    pulse(4'b0011, 10);
    rd(0, 0, d, ds, v);
    checks++;
    if (d !== 16'd10 || ds !== 16'd10) begin
      errors++;
      $display("FAIL count_ch0 got %h/%h exp 000a", d, ds);
    end
    rd(1, 0, d, ds, v);
    checks++;
    if (d !== 16'd0 || ds !== 16'd0) begin
      errors++;
      $display("FAIL count_ch1_dis got %h/%h exp 0000", d, ds);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] d, ds;
    logic v;
    wr(2, 2, 16'h0001);
    wr(2, 0, 16'hFFFE);
    pulse(4'b0100, 3);
    rd(2, 0, d, ds, v);
    checks++;
    if (d !== 16'h0001 || ds !== 16'hFFFF) begin
      errors++;
      $display("FAIL ovf_count got %h/%h exp 0001/ffff", d, ds);
    end
    rd(2, 3, d, ds, v);
    checks++;
    if (d !== 16'h0003 || ds !== 16'h0003) begin
      errors++;
      $display("FAIL ovf_status got %h/%h exp 0003", d, ds);
    end
    checks++;
    if (ovf_o !== 4'b0100 || ovf_s !== 4'b0100 ||
        irq_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pin got %b/%b irq=%b exp 0100 irq 0",
               ovf_o, ovf_s, irq_o);
    end
    wr(2, 3, 16'h0003);
    checks++;
    if (ovf_o !== 4'b0000 || ovf_s !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_clear got %b/%b exp 0000", ovf_o, ovf_s);
    end
  endtask

  task automatic test_hit;
    logic [15:0] d, ds;
    logic v;
    wr(3, 1, 16'd5);
    wr(3, 2, 16'h0003);
    pulse(4'b1000, 4);
    checks++;
    if (irq_o !== 1'b0 || irq_s !== 1'b0) begin
      errors++;
      $display("FAIL hit_early irq %b/%b exp 0", irq_o, irq_s);
    end
    pulse(4'b1000, 1);
    checks++;
    if (irq_o !== 1'b1 || irq_s !== 1'b1) begin
      errors++;
      $display("FAIL hit_irq irq %b/%b exp 1", irq_o, irq_s);
    end
    wr(3, 3, 16'h0002);
    checks++;
    if (irq_o !== 1'b0 || irq_s !== 1'b0) begin
      errors++;
      $display("FAIL hit_w1c irq %b/%b exp 0", irq_o, irq_s);
    end
    wr(3, 0, 16'd4);
    @(negedge clk);
    ev_i = 4'b1000; we_i = 1'b1;
    addr_i = 4'(3 * 4 + 3); wdata_i = 16'h0002;
    @(negedge clk);
    ev_i = '0; we_i = 1'b0;
    checks++;
    if (irq_o !== 1'b1 || irq_s !== 1'b1) begin
      errors++;
      $display("FAIL hit_set_wins irq %b/%b exp 1", irq_o, irq_s);
    end
    rd(3, 3, d, ds, v);
    checks++;
    if (d !== 16'h0002 || ds !== 16'h0002) begin
      errors++;
      $display("FAIL hit_status got %h/%h exp 0002", d, ds);
    end
  endtask

  task automatic test_write_collide;
    logic [15:0] d, ds;
    logic v;
    @(negedge clk);
    ev_i = 4'b0001; we_i = 1'b1; re_i = 1'b1;
    addr_i = 4'h0; wdata_i = 16'd100;
    @(negedge clk);
    ev_i = '0; we_i = 1'b0; re_i = 1'b0;
    checks++;
    if (rdata_o !== 16'd10 || rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL rw_old got %h v=%b exp 000a v=1",
               rdata_o, rvalid_o);
    end
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b0 || rdata_o !== 16'd10) begin
      errors++;
      $display("FAIL rw_pulse got %h v=%b exp 000a v=0",
               rdata_o, rvalid_o);
    end
    rd(0, 0, d, ds, v);
    checks++;
    if (d !== 16'd100 || ds !== 16'd100) begin
      errors++;
      $display("FAIL rw_write_wins got %h/%h exp 0064", d, ds);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    re_i = 1'b1; addr_i = 4'(3 * 4 + 1);
    @(negedge clk);
    checks++;
    if (rdata_o !== 16'd5 || rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got %h v=%b exp 0005 v=1",
               rdata_o, rvalid_o);
    end
    addr_i = 4'h0;
    @(negedge clk);
    re_i = 1'b0;
    checks++;
    if (rdata_o !== 16'd100 || rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got %h v=%b exp 0064 v=1",
               rdata_o, rvalid_o);
    end
    @(negedge clk);
    checks++;
    if (rdata_o !== 16'd100 || rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold got %h v=%b exp 0064 v=0",
               rdata_o, rvalid_o);
    end
  endtask

  task automatic test_async_reset;
    logic [15:0] d, ds;
    logic v;
    wr(2, 0, 16'hFFFF);
    pulse(4'b0100, 1);
    wr(0, 0, 16'd0);
    pulse(4'b0001, 7);
    rd(0, 0, d, ds, v);
    checks++;
    if (d !== 16'd7 || ovf_o !== 4'b0100 || irq_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got %h ovf=%b irq=%b exp 0007 0100 1",
               d, ovf_o, irq_o);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ovf_o !== 4'h0 || ovf_s !== 4'h0 || irq_o !== 1'b0 ||
        irq_s !== 1'b0 || rdata_o !== 16'h0) begin
      errors++;
      $display("FAIL async_rst ovf=%b/%b irq=%b/%b rd=%h exp 0",
               ovf_o, ovf_s, irq_o, irq_s, rdata_o);
    end
    @(negedge clk);
    rst = 1'b1;
    rd(0, 0, d, ds, v);
    checks++;
    if (d !== 16'd0 || ds !== 16'd0) begin
      errors++;
      $display("FAIL rst_count got %h/%h exp 0000", d, ds);
    end
    rd(3, 1, d, ds, v);
    checks++;
    if (d !== 16'hFFFF || ds !== 16'hFFFF) begin
      errors++;
      $display("FAIL rst_thresh got %h/%h exp ffff", d, ds);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_overflow();
    test_hit();
    test_write_collide();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
